// File: rtl/control_fsm.sv
// control_fsm: multi-cycle fetch/decode/execute/memory sequencer for the 16-bit CPU.
// Decodes the latched IR into ALU, register-file, PC and memory controls and owns the PSR.
module control_fsm #(
  parameter int DATA_W      = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              alu_carry,
  input  logic              alu_low,
  input  logic              alu_flag,
  input  logic              alu_zero,
  input  logic              alu_negative,
  output logic [3:0]        op_code,
  output logic [3:0]        ext_code,
  output logic              immediate_mode,
  output logic              is_branch_op,
  output logic              carry_in,
  output logic [3:0]        rdest_idx,
  output logic [3:0]        rsrc_idx,
  output logic [7:0]        imm8,
  output logic              reg_we,
  output logic [1:0]        wb_sel,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_addr_sel,
  output logic [4:0]        psr,
  output logic              illegal,
  output logic              bus_err
);
  localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] ir;
  logic [CW-1:0] cnt;
  logic [3:0] op, ext, cnd;
  logic [15:0] cond_tab;
  logic alu_r, cmp, alu_i, cmpi, bcc, jcc, jal, ld, st, cf_op, fields, waiting, timeout, taken;
  assign op    = ir[15:12];
  assign ext   = ir[7:4];
  assign cnd   = ir[11:8];
  assign alu_r = op == 4'h0 && ext inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hD};
  assign cmp   = op == 4'h0 && ext == 4'hB;
  assign alu_i = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hF};
  assign cmpi  = op == 4'hB;
  assign bcc   = op == 4'hC;
  assign jcc   = op == 4'h4 && ext == 4'hC;
  assign jal   = op == 4'h4 && ext == 4'h8;
  assign ld    = op == 4'h4 && ext == 4'h0;
  assign st    = op == 4'h4 && ext == 4'h4;
  // ADD/ADDC/SUB/SUBC and ADDI/SUBI update carry and overflow; the unsigned adds do not
  assign cf_op = (op == 4'h0 && ext inside {4'h5, 4'h7, 4'h9, 4'hA}) || op inside {4'h5, 4'h9};
  // indexed by condition code; psr = {C,L,F,Z,N}
  assign cond_tab = {1'b0, 1'b1, psr[0] | psr[1], !psr[0] & !psr[1], psr[3] | psr[1], !psr[3] & !psr[1],
                     !psr[2], psr[2], !psr[0], psr[0], !psr[3], psr[3], !psr[4], psr[4], !psr[1], psr[1]};
  assign taken   = cond_tab[cnd];
  assign fields  = state inside {DECODE, EXEC, MEM};
  assign waiting = (state == FETCH || state == MEM) && !mem_ack;
  assign timeout = MEM_TIMEOUT != 0 && waiting && cnt == LAST;
  assign op_code        = fields ? op : '0;
  assign ext_code       = fields ? ext : '0;
  assign rdest_idx      = fields ? cnd : '0;
  assign rsrc_idx       = fields ? ir[3:0] : '0;
  assign imm8           = fields ? ir[7:0] : '0;
  assign immediate_mode = fields && (alu_i || cmpi);
  assign carry_in       = psr[4];
  always_comb begin
    state_n      = state;
    is_branch_op = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    illegal      = 1'b0;
    bus_err      = 1'b0;
    case (state)
      IDLE:   state_n = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        bus_err = timeout;
        state_n = mem_ack ? DECODE : FETCH;
      end
      DECODE: state_n = EXEC;
      EXEC: begin
        is_branch_op = bcc;
        reg_we       = alu_r || alu_i || jal;
        wb_sel       = jal ? 2'b10 : 2'b00;
        pc_we        = !(ld || st);
        pc_sel       = (bcc && taken) ? 2'b01 : ((jcc && taken) || jal) ? 2'b10 : 2'b00;
        illegal      = !(alu_r || cmp || alu_i || cmpi || bcc || jcc || jal || ld || st);
        state_n      = (ld || st) ? MEM : FETCH;
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = st;
        reg_we       = ld && mem_ack;
        wb_sel       = (ld && mem_ack) ? 2'b01 : 2'b00;
        pc_we        = mem_ack || timeout;
        bus_err      = timeout;
        state_n      = (mem_ack || timeout) ? FETCH : MEM;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= '0;
      psr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (waiting && !timeout) ? cnt + 1'b1 : '0;
      if (state == FETCH && mem_ack) ir <= mem_rdata;
      if (state == EXEC && cf_op) {psr[4], psr[2]} <= {alu_carry, alu_flag};
      if (state == EXEC && (cmp || cmpi)) {psr[3], psr[1], psr[0]} <= {alu_low, alu_zero, alu_negative};
    end
  end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: instruction-level model of the sequencer compared against the DUT every cycle,
// plus hand-computed spot checks of the scenarios that matter most.
module tb_control_fsm;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_n, mem_ack, alu_carry, alu_low, alu_flag, alu_zero, alu_negative;
  logic [15:0] mem_rdata;
  logic [3:0] op_code, ext_code, rdest_idx, rsrc_idx;
  logic immediate_mode, is_branch_op, carry_in, reg_we, pc_we, mem_req, mem_we, mem_addr_sel, illegal, bus_err;
  logic [7:0] imm8;
  logic [1:0] wb_sel, pc_sel;
  logic [4:0] psr;

  control_fsm #(.DATA_W(16), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_carry(alu_carry), .alu_low(alu_low), .alu_flag(alu_flag), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .op_code(op_code), .ext_code(ext_code), .immediate_mode(immediate_mode), .is_branch_op(is_branch_op),
    .carry_in(carry_in), .rdest_idx(rdest_idx), .rsrc_idx(rsrc_idx), .imm8(imm8), .reg_we(reg_we),
    .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .psr(psr), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op_code, ext_code;
    logic immediate_mode, is_branch_op, carry_in;
    logic [3:0] rdest_idx, rsrc_idx;
    logic [7:0] imm8;
    logic reg_we;
    logic [1:0] wb_sel;
    logic pc_we;
    logic [1:0] pc_sel;
    logic mem_req, mem_we, mem_addr_sel;
    logic [4:0] psr;
    logic illegal, bus_err;
  } outs_t;

  typedef enum {K_ALUR, K_CMP, K_ALUI, K_CMPI, K_B, K_J, K_JAL, K_LD, K_ST, K_ILL} kind_t;

  outs_t act, exp;
  assign act = {op_code, ext_code, immediate_mode, is_branch_op, carry_in, rdest_idx, rsrc_idx, imm8,
                reg_we, wb_sel, pc_we, pc_sel, mem_req, mem_we, mem_addr_sel, psr, illegal, bus_err};

  int checks = 0, errors = 0;
  logic chk_en;
  string phase = "init";
  logic [4:0] m_psr;
  logic [15:0] cur_ir;

  always @(negedge clk) if (chk_en) begin
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle[%s] ir=%h: outputs %h expected %h", phase, cur_ir, act, exp);
    end
  end

  task automatic check(string n, logic [15:0] got, logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, want);
    end
  endtask

  function automatic kind_t classify(logic [15:0] ir);
    logic [3:0] o, x;
    o = ir[15:12];
    x = ir[7:4];
    if (o == 4'h0) begin
      if (x == 4'hB) return K_CMP;
      if (x inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hD}) return K_ALUR;
      return K_ILL;
    end
    if (o inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hF}) return K_ALUI;
    if (o == 4'hB) return K_CMPI;
    if (o == 4'hC) return K_B;
    if (o == 4'h4) begin
      if (x == 4'hC) return K_J;
      if (x == 4'h8) return K_JAL;
      if (x == 4'h0) return K_LD;
      if (x == 4'h4) return K_ST;
    end
    return K_ILL;
  endfunction

  function automatic bit cond_true(logic [3:0] cc, logic [4:0] p);
    bit c, l, f, z, n;
    {c, l, f, z, n} = p;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return l;
      4'h5: return !l;
      4'h6: return n;
      4'h7: return !n;
      4'h8: return f;
      4'h9: return !f;
      4'hA: return !l && !z;
      4'hB: return l || z;
      4'hC: return !n && !z;
      4'hD: return n || z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic outs_t idle_exp();
    outs_t e = '0;
    e.psr = m_psr;
    e.carry_in = m_psr[4];
    return e;
  endfunction

  function automatic outs_t fld(outs_t e);
    kind_t k = classify(cur_ir);
    e.op_code = cur_ir[15:12];
    e.ext_code = cur_ir[7:4];
    e.rdest_idx = cur_ir[11:8];
    e.rsrc_idx = cur_ir[3:0];
    e.imm8 = cur_ir[7:0];
    e.immediate_mode = k == K_ALUI || k == K_CMPI;
    return e;
  endfunction

  function automatic outs_t exec_exp();
    outs_t e = fld(idle_exp());
    kind_t k = classify(cur_ir);
    bit t = cond_true(cur_ir[11:8], m_psr);
    e.pc_we = !(k == K_LD || k == K_ST);
    case (k)
      K_ALUR, K_ALUI: e.reg_we = 1'b1;
      K_JAL: begin e.reg_we = 1'b1; e.wb_sel = 2'b10; e.pc_sel = 2'b10; end
      K_B: begin e.is_branch_op = 1'b1; e.pc_sel = t ? 2'b01 : 2'b00; end
      K_J: e.pc_sel = t ? 2'b10 : 2'b00;
      K_ILL: e.illegal = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic begin_cyc(string p);
    @(posedge clk);
    #1;
    phase = p;
    mem_ack = 1'b0;
    mem_rdata = 16'($urandom);
    {alu_carry, alu_low, alu_flag, alu_zero, alu_negative} = 5'($urandom);
    exp = idle_exp();
  endtask

  task automatic end_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic t_fetch(logic [15:0] instr, int waits);
    for (int i = 0; i < waits; i++) begin
      begin_cyc("fetch_wait");
      exp.mem_req = 1'b1;
      exp.bus_err = (i + 1) % TO == 0;
      end_cyc();
    end
    begin_cyc("fetch_ack");
    mem_ack = 1'b1;
    mem_rdata = instr;
    exp.mem_req = 1'b1;
    end_cyc();
    cur_ir = instr;
    begin_cyc("decode");
    exp = fld(exp);
    end_cyc();
  endtask

  task automatic t_exec(logic [4:0] f);
    kind_t k = classify(cur_ir);
    bit cf;
    begin_cyc("exec");
    {alu_carry, alu_low, alu_flag, alu_zero, alu_negative} = f;
    exp = exec_exp();
    end_cyc();
    cf = (cur_ir[15:12] == 4'h0 && cur_ir[7:4] inside {4'h5, 4'h7, 4'h9, 4'hA}) || cur_ir[15:12] inside {4'h5, 4'h9};
    if (cf) begin m_psr[4] = f[4]; m_psr[2] = f[2]; end
    if (k == K_CMP || k == K_CMPI) begin m_psr[3] = f[3]; m_psr[1] = f[1]; m_psr[0] = f[0]; end
  endtask

  task automatic run(logic [15:0] instr, int fw, logic [4:0] f);
    t_fetch(instr, fw);
    t_exec(f);
  endtask

  task automatic t_mem(int n, bit ack);
    bit is_ld = classify(cur_ir) == K_LD;
    for (int i = 0; i < n; i++) begin
      begin_cyc("mem");
      exp = fld(exp);
      exp.mem_req = 1'b1;
      exp.mem_addr_sel = 1'b1;
      exp.mem_we = classify(cur_ir) == K_ST;
      if (i == n - 1 && ack) begin
        mem_ack = 1'b1;
        exp.reg_we = is_ld;
        exp.wb_sel = is_ld ? 2'b01 : 2'b00;
        exp.pc_we = 1'b1;
      end else if ((i + 1) % TO == 0) begin
        exp.bus_err = 1'b1;
        exp.pc_we = 1'b1;
      end
      end_cyc();
    end
  endtask

  initial begin
    logic [4:0] pv;
    rst_n = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    {alu_carry, alu_low, alu_flag, alu_zero, alu_negative} = '0;
    m_psr = '0;
    cur_ir = '0;
    exp = '0;
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    begin_cyc("reset");
    end_cyc();
    check("reset_mem_req", 16'(mem_req), 16'd0);
    check("reset_psr", 16'(psr), 16'd0);
    begin_cyc("reset");
    end_cyc();
    begin_cyc("idle");
    rst_n = 1'b1;
    end_cyc();
    // ADD r3,r1 with carry out
    run(16'h0351, 2, 5'b10000);
    check("add_ext_code", 16'(ext_code), 16'h5);
    check("add_op_code", 16'(op_code), 16'h0);
    check("add_reg_we", 16'(reg_we), 16'd1);
    check("add_wb_sel", 16'(wb_sel), 16'd0);
    check("add_pc_sel", 16'(pc_sel), 16'd0);
    check("add_psr_model", 16'(m_psr), 16'b10000);
    // CMPI: L set, C/F held
    run(16'hB205, 5, 5'b01100);
    check("cmpi_imm_mode", 16'(immediate_mode), 16'd1);
    check("cmpi_reg_we", 16'(reg_we), 16'd0);
    check("cmpi_psr_model", 16'(m_psr), 16'b11000);
    // Bcond EQ taken / not taken
    run(16'h01B2, 0, 5'b00010);
    run(16'hC0FE, 0, 5'($urandom));
    check("beq_taken_br", 16'(is_branch_op), 16'd1);
    check("beq_taken_sel", 16'(pc_sel), 16'd1);
    run(16'h01B2, 0, 5'b00000);
    run(16'hC0FE, 1, 5'($urandom));
    check("beq_not_taken_sel", 16'(pc_sel), 16'd0);
    // JAL r10 via r3
    run(16'h4A83, 0, 5'($urandom));
    check("jal_wb_sel", 16'(wb_sel), 16'd2);
    check("jal_pc_sel", 16'(pc_sel), 16'd2);
    check("jal_rdest", 16'(rdest_idx), 16'hA);
    // LOAD r4,(r6), ack one cycle late
    run(16'h4406, 0, 5'($urandom));
    check("load_exec_pc_we", 16'(pc_we), 16'd0);
    t_mem(2, 1'b1);
    check("load_mem_we", 16'(mem_we), 16'd0);
    check("load_addr_sel", 16'(mem_addr_sel), 16'd1);
    check("load_reg_we", 16'(reg_we), 16'd1);
    check("load_wb_sel", 16'(wb_sel), 16'd1);
    check("load_rdest", 16'(rdest_idx), 16'd4);
    run(16'h4546, 0, 5'($urandom));
    t_mem(1, 1'b1);
    check("stor_mem_we", 16'(mem_we), 16'd1);
    check("stor_reg_we", 16'(reg_we), 16'd0);
    // STOR with no ack, then ack on the last allowed cycle
    run(16'h4546, 0, 5'($urandom));
    t_mem(TO, 1'b0);
    check("stor_timeout_bus_err", 16'(bus_err), 16'd1);
    check("stor_timeout_pc_we", 16'(pc_we), 16'd1);
    check("stor_timeout_pc_sel", 16'(pc_sel), 16'd0);
    run(16'h4546, 0, 5'($urandom));
    t_mem(TO, 1'b1);
    check("stor_late_ack_bus_err", 16'(bus_err), 16'd0);
    // reset in the middle of a LOAD's memory phase
    run(16'h4406, 0, 5'($urandom));
    t_mem(1, 1'b0);
    begin_cyc("mem_reset");
    mem_ack = 1'b1;
    rst_n = 1'b0;
    m_psr = '0;
    exp = idle_exp();
    end_cyc();
    check("midreset_reg_we", 16'(reg_we), 16'd0);
    check("midreset_mem_req", 16'(mem_req), 16'd0);
    check("midreset_psr", 16'(psr), 16'd0);
    begin_cyc("release");
    rst_n = 1'b1;
    end_cyc();
    run(16'h7000, 1, 5'($urandom));
    check("illegal_pulse", 16'(illegal), 16'd1);
    check("illegal_pc_we", 16'(pc_we), 16'd1);
    check("illegal_reg_we", 16'(reg_we), 16'd0);
    // every condition against every PSR value, as Bcond and Jcond
    for (int p = 0; p < 32; p++) begin
      pv = 5'(p);
      run(16'h0351, 0, {pv[4], 1'b0, pv[2], 2'b00});
      run(16'h01B2, 0, {1'b0, pv[3], 1'b0, pv[1:0]});
      for (int c = 0; c < 16; c++) begin
        run({4'hC, 4'(c), 8'h05}, 0, 5'($urandom));
        run({4'h4, 4'(c), 4'hC, 4'h2}, 0, 5'($urandom));
      end
    end
    check("sweep_psr_model", 16'(m_psr), 16'h1F);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
